sar_search_controller: RTL and testbench

Successive-approximation search engine that drives a trial value onto the A input of an external magnitude comparator and consumes its AeqB/AgtB/AltB flags to recover the unknown value on the comparator's B input. It is the consuming end of the comparator interface. It sits beside the team's combinational comparator and converts three one-hot relational flags into a binary result, MSB first, with early termination on equality.

---
 rtl/sar_pkg.sv | 17 +
 rtl/four_bit_comparator.sv | 14 +
 rtl/sar_search_controller.sv | 113 +++++++++++
 tb/tb_sar_search_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

   localparam int unsigned SAR_DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRIAL = 2'd1,
      DONE  = 2'd2
   } sar_state_t;

   // True when exactly one of the three relational flags is asserted.
   function automatic logic onehot3(input logic eq, input logic gt, input logic lt);
      return (eq ^ gt ^ lt) & ~(eq & gt & lt);
   endfunction

endpackage

// File: rtl/four_bit_comparator.sv
// Combinational 4-bit unsigned magnitude comparator producing one-hot relational flags.
module four_bit_comparator (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       eq_c,
   output logic       gt_c,
   output logic       lt_c
);

   assign eq_c = (a == b);
   assign gt_c = (a > b);
   assign lt_c = (a < b);

endmodule

// File: rtl/sar_search_controller.sv
// Binary search over an external comparator: drives trial values on guess and
// resolves the comparator's B operand MSB first, exiting early on equality.
module sar_search_controller
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH = SAR_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             error
);

   localparam int unsigned IDX_W = $clog2(WIDTH);

   sar_state_t       state_q,     state_d;
   logic [WIDTH-1:0] guess_q,     guess_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             error_q,     error_d;
   logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;
   logic [WIDTH-1:0] committed_q, committed_d;

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] next_val;

   // Trial bit under test and the value kept after this comparison.
   assign mask     = WIDTH'(1) << bit_idx_q;
   assign next_val = cmp_gt ? (guess_q & ~mask) : guess_q;

   always_comb begin
      state_d     = state_q;
      guess_d     = guess_q;
      result_d    = result_q;
      error_d     = error_q;
      bit_idx_d   = bit_idx_q;
      committed_d = committed_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               committed_d = '0;
               guess_d     = WIDTH'(1) << (WIDTH - 1);
               bit_idx_d   = IDX_W'(WIDTH - 1);
               error_d     = 1'b0;
               state_d     = TRIAL;
            end
         end
         TRIAL: begin
            if (!onehot3(cmp_eq, cmp_gt, cmp_lt)) begin
               error_d  = 1'b1;
               result_d = '0;
               state_d  = DONE;
            end else if (cmp_eq) begin
               result_d = guess_q;
               state_d  = DONE;
            end else if (bit_idx_q == '0) begin
               result_d = next_val;
               state_d  = DONE;
            end else begin
               // mask >> 1 is the next lower trial bit
               committed_d = next_val;
               guess_d     = next_val | (mask >> 1);
               bit_idx_d   = bit_idx_q - IDX_W'(1);
            end
         end
         default: begin
            guess_d = '0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == TRIAL);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         guess_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         error_q     <= 1'b0;
         bit_idx_q   <= '0;
         committed_q <= '0;
      end else begin
         state_q     <= state_d;
         guess_q     <= guess_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         error_q     <= error_d;
         bit_idx_q   <= bit_idx_d;
         committed_q <= committed_d;
      end
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign error  = error_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Scoreboard bench: SAR controller coupled to a 4-bit comparator, with flag override for errors.
module tb_sar_search_controller;

   typedef struct {
      logic [3:0] res;
      logic       err;
      int         k;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] target = 4'd0;
   logic       inj_en = 1'b0;
   logic [3:0] inj_guess = 4'd0;

   logic       cmp_eq, cmp_gt, cmp_lt;
   logic       ceq, cgt, clt, inj;
   logic [3:0] guess, result;
   logic       busy, done, error;

   exp_t       exp_q[$];
   logic [3:0] gq[$];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   four_bit_comparator u_cmp (
      .a    (guess),
      .b    (target),
      .eq_c (ceq),
      .gt_c (cgt),
      .lt_c (clt)
   );

   // Behavioural override: force gt and lt together when the chosen guess is on the bus.
   assign inj    = inj_en && busy && (guess == inj_guess);
   assign cmp_eq = inj ? 1'b0 : ceq;
   assign cmp_gt = inj ? 1'b1 : cgt;
   assign cmp_lt = inj ? 1'b1 : clt;

   sar_search_controller #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cmp_eq (cmp_eq),
      .cmp_gt (cmp_gt),
      .cmp_lt (cmp_lt),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .error  (error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: consumes expected guesses while busy and expected results on done.
   int   busy_cnt = 0;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) begin
            if (gq.size() == 0) begin
               check("unexpected_busy", 32'd1, 32'd0);
            end else begin
               check("guess", 32'(guess), 32'(gq.pop_front()));
            end
            busy_cnt++;
         end
         if (done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("busy_low_at_done", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("error", 32'(error), 32'(e.err));
               check("trial_count", 32'(busy_cnt), 32'(e.k));
            end
            busy_cnt = 0;
         end
         prev_done = done;
      end
   end

   task automatic wait_done();
      int t = 0;
      while (!done && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!done) check("done_timeout", 32'd1, 32'd0);
      @(posedge clk);
   endtask

   // gs holds up to four expected guesses, first trial in the top nibble.
   task automatic run(input logic [3:0] tgt, input logic [15:0] gs, input int n,
                      input logic [3:0] res, input logic err);
      for (int i = 0; i < n; i++) gq.push_back(gs[15-4*i -: 4]);
      exp_q.push_back('{res, err, n});
      target = tgt;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      wait_done();
      repeat (2) @(negedge clk);
      check("result_held", 32'(result), 32'(res));
      check("error_held", 32'(error), 32'(err));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_guess"},  32'(guess),  32'd0);
      check({tag, "_busy"},   32'(busy),   32'd0);
      check({tag, "_done"},   32'(done),   32'd0);
      check({tag, "_result"}, 32'(result), 32'd0);
      check({tag, "_error"},  32'(error),  32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(4'd5,  16'h8465, 4, 4'd5,  1'b0);
      run(4'd8,  16'h8000, 1, 4'd8,  1'b0);
      run(4'd0,  16'h8421, 4, 4'd0,  1'b0);
      run(4'd15, 16'h8CEF, 4, 4'd15, 1'b0);
      run(4'd3,  16'h8423, 4, 4'd3,  1'b0);

      // Second trial (guess 4) sees gt and lt together.
      inj_guess = 4'd4;
      inj_en    = 1'b1;
      run(4'd5,  16'h8400, 2, 4'd0,  1'b1);
      inj_en    = 1'b0;

      // start pulses during TRIAL and during DONE must be ignored.
      gq.push_back(4'd8); gq.push_back(4'd4); gq.push_back(4'd6);
      exp_q.push_back('{4'd6, 1'b0, 3});
      target = 4'd6;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      @(posedge clk) #1 start = 1'b1;
      check("in_done_cycle", 32'(done), 32'd1);
      @(posedge clk) #1 start = 1'b0;
      repeat (6) @(negedge clk);
      check("no_restart_busy", 32'(busy), 32'd0);
      check("poke_result_held", 32'(result), 32'd6);

      // Reset during trial 2 of target 9: only the first guess is ever observed.
      gq.push_back(4'd8);
      target = 4'd9;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      @(posedge clk) #1;
      check("trial2_guess", 32'(guess), 32'd12);
      #1 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      @(posedge clk) #1;
      check_reset_outputs("reset_held");
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      run(4'd9, 16'h8CA9, 4, 4'd9, 1'b0);

      repeat (3) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("guess_q_empty", 32'(gq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
